// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_WB_R   = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_WB_I   = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_JAL    = 4'd11,
    ST_JR     = 4'd12,
    ST_HALT   = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    IC_R, IC_JR, IC_MEMI, IC_ADDI, IC_BR, IC_J, IC_JAL, IC_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational instruction classifier: op/funct to instruction class and
// the ALU operation an R-type instruction needs.
module mc_op_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] r_alu_op,
  output logic       r_funct_ok
);

  // Map funct to ALU op and classify the opcode.
  always_comb begin
    iclass     = IC_ILLEGAL;
    r_alu_op   = ALU_ADD;
    r_funct_ok = 1'b0;
    case (funct)
      FN_ADD: begin r_alu_op = ALU_ADD; r_funct_ok = 1'b1; end
      FN_SUB: begin r_alu_op = ALU_SUB; r_funct_ok = 1'b1; end
      FN_AND: begin r_alu_op = ALU_AND; r_funct_ok = 1'b1; end
      FN_OR:  begin r_alu_op = ALU_OR;  r_funct_ok = 1'b1; end
      FN_SLT: begin r_alu_op = ALU_SLT; r_funct_ok = 1'b1; end
      default: ;
    endcase
    case (op)
      OP_RTYPE:      iclass = (funct == FN_JR) ? IC_JR : IC_R;
      OP_LW, OP_SW:  iclass = IC_MEMI;
      OP_ADDI:       iclass = IC_ADDI;
      OP_BEQ, OP_BNE: iclass = IC_BR;
      OP_J:          iclass = IC_J;
      OP_JAL:        iclass = IC_JAL;
      default:       iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: state register plus output/next-state decode.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_addr_sel,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       halted,
  output logic [3:0] state
);

  state_t     state_q;
  iclass_t    dec_class;
  logic [2:0] dec_alu_op;
  logic       dec_funct_ok;

  // Decode results captured in DECODE, so later states ignore op changes:
  // sub_q is SW for memory ops and BNE for branches.
  iclass_t    cls_q;
  logic       sub_q;
  logic [2:0] r_alu_q;
  logic       r_ok_q;

  mc_op_decode u_dec (
    .op         (op),
    .funct      (funct),
    .iclass     (dec_class),
    .r_alu_op   (dec_alu_op),
    .r_funct_ok (dec_funct_ok)
  );

  assign state = state_q;

  // State register and next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cls_q   <= IC_ILLEGAL;
      sub_q   <= 1'b0;
      r_alu_q <= '0;
      r_ok_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH:  if (mem_ready) state_q <= ST_DECODE;
        ST_DECODE: begin
          cls_q   <= dec_class;
          sub_q   <= (op == OP_SW) || (op == OP_BNE);
          r_alu_q <= dec_alu_op;
          r_ok_q  <= dec_funct_ok;
          case (dec_class)
            IC_R:             state_q <= ST_EXEC_R;
            IC_JR:            state_q <= ST_JR;
            IC_MEMI, IC_ADDI: state_q <= ST_EXEC_I;
            IC_BR:            state_q <= ST_BRANCH;
            IC_J:             state_q <= ST_JUMP;
            IC_JAL:           state_q <= ST_JAL;
            default:          state_q <= ST_HALT;
          endcase
        end
        ST_EXEC_R: state_q <= r_ok_q ? ST_WB_R : ST_HALT;
        ST_EXEC_I: begin
          if (cls_q == IC_ADDI) state_q <= ST_WB_I;
          else                  state_q <= sub_q ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD: if (mem_ready) state_q <= ST_WB_MEM;
        ST_MEM_WR: if (mem_ready) state_q <= ST_FETCH;
        ST_HALT:   state_q <= ST_HALT;
        default:   state_q <= ST_FETCH;
      endcase
    end
  end

  // Datapath controls from state, with the few Mealy terms on mem_ready/zero.
  always_comb begin
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = M2R_ALUOUT;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_ADD;
    pc_src       = PC_ALU;
    retire       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SH;
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_q;
      end
      ST_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = REG_DST_RD;
        retire  = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: mem_addr_sel = 1'b1;
      ST_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        mem_addr_sel = 1'b1;
        mem_we       = 1'b1;
        retire       = mem_ready;
      end
      ST_WB_I: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = sub_q ? ~zero : zero;
        retire    = 1'b1;
      end
      ST_JUMP: begin
        pc_src = PC_JUMP;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      ST_JAL: begin
        pc_src     = PC_JUMP;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = M2R_PC;
        retire     = 1'b1;
      end
      ST_JR: begin
        pc_src = PC_REG;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction pushes
// its expected per-cycle output trace; drain pops and compares every cycle.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, mem_addr_sel, mem_we, reg_we, alu_src_a, retire, halted;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we),
    .mem_addr_sel(mem_addr_sel), .mem_we(mem_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .retire(retire), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  logic [22:0] act;
  assign act = {pc_we, ir_we, mem_addr_sel, mem_we, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src, retire, halted, state};

  typedef struct {
    logic [22:0] vec;
    logic        rdy;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
  } entry_t;

  entry_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned step     = 0;

  // Expected outputs for one cycle, written from the state descriptions.
  function automatic logic [22:0] exp_vec(input state_t st, input logic rdy,
                                          input logic z, input logic bne,
                                          input logic [2:0] aop);
    logic pcw, irw, mas, mw, rw, sa, ret, hlt;
    logic [1:0] rd, m2r, sbv, ps;
    logic [2:0] ao;
    pcw = 0; irw = 0; mas = 0; mw = 0; rw = 0; sa = 0; ret = 0; hlt = 0;
    rd = 2'b00; m2r = 2'b00; sbv = 2'b00; ps = 2'b00; ao = 3'b000;
    case (st)
      ST_FETCH:  begin sbv = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: sbv = 2'b11;
      ST_EXEC_R: begin sa = 1; ao = aop; end
      ST_WB_R:   begin rw = 1; rd = 2'b01; ret = 1; end
      ST_EXEC_I: begin sa = 1; sbv = 2'b10; end
      ST_MEM_RD: mas = 1;
      ST_WB_MEM: begin rw = 1; m2r = 2'b01; ret = 1; end
      ST_MEM_WR: begin mas = 1; mw = 1; ret = rdy; end
      ST_WB_I:   begin rw = 1; ret = 1; end
      ST_BRANCH: begin sa = 1; ao = 3'b001; ps = 2'b01; pcw = bne ? ~z : z; ret = 1; end
      ST_JUMP:   begin ps = 2'b10; pcw = 1; ret = 1; end
      ST_JAL:    begin ps = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; ret = 1; end
      ST_JR:     begin ps = 2'b11; pcw = 1; ret = 1; end
      ST_HALT:   hlt = 1;
      default: ;
    endcase
    return {pcw, irw, mas, mw, rw, rd, m2r, sa, sbv, ao, ps, ret, hlt, 4'(st)};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Push one expected cycle; op outside DECODE is scrambled to prove it is ignored.
  task automatic push(input state_t st, input logic rdy, input logic z,
                      input logic bne, input logic [2:0] aop,
                      input logic [5:0] op_real, input logic [5:0] fn);
    entry_t e;
    e.vec = exp_vec(st, rdy, z, bne, aop);
    e.rdy = rdy;
    e.z   = z;
    e.op  = (st == ST_DECODE) ? op_real : 6'($urandom);
    e.fn  = fn;
    sb.push_back(e);
  endtask

  // Expected trace of one instruction, including requested stall cycles.
  task automatic issue(input logic [5:0] o, input logic [5:0] fn, input logic z,
                       input int unsigned fstall, input int unsigned mstall,
                       input int unsigned halt_cycles);
    logic [2:0] aop;
    logic       fok;
    for (int unsigned i = 0; i < fstall; i++) push(ST_FETCH, 0, rbit(), 0, 0, o, fn);
    push(ST_FETCH, 1, rbit(), 0, 0, o, fn);
    push(ST_DECODE, rbit(), rbit(), 0, 0, o, fn);
    fok = 1'b1;
    case (fn)
      6'b100000: aop = 3'b000;
      6'b100010: aop = 3'b001;
      6'b100100: aop = 3'b010;
      6'b100101: aop = 3'b011;
      6'b101010: aop = 3'b100;
      default:   begin aop = 3'b000; fok = 1'b0; end
    endcase
    case (o)
      6'b000000: begin
        if (fn == 6'b001000) push(ST_JR, rbit(), rbit(), 0, 0, o, fn);
        else begin
          push(ST_EXEC_R, rbit(), rbit(), 0, aop, o, fn);
          if (fok) push(ST_WB_R, rbit(), rbit(), 0, 0, o, fn);
          else for (int unsigned i = 0; i < halt_cycles; i++)
            push(ST_HALT, rbit(), rbit(), 0, 0, o, fn);
        end
      end
      6'b100011: begin
        push(ST_EXEC_I, rbit(), rbit(), 0, 0, o, fn);
        for (int unsigned i = 0; i < mstall; i++) push(ST_MEM_RD, 0, rbit(), 0, 0, o, fn);
        push(ST_MEM_RD, 1, rbit(), 0, 0, o, fn);
        push(ST_WB_MEM, rbit(), rbit(), 0, 0, o, fn);
      end
      6'b101011: begin
        push(ST_EXEC_I, rbit(), rbit(), 0, 0, o, fn);
        for (int unsigned i = 0; i < mstall; i++) push(ST_MEM_WR, 0, rbit(), 0, 0, o, fn);
        push(ST_MEM_WR, 1, rbit(), 0, 0, o, fn);
      end
      6'b001000: begin
        push(ST_EXEC_I, rbit(), rbit(), 0, 0, o, fn);
        push(ST_WB_I, rbit(), rbit(), 0, 0, o, fn);
      end
      6'b000100: push(ST_BRANCH, rbit(), z, 0, 0, o, fn);
      6'b000101: push(ST_BRANCH, rbit(), z, 1, 0, o, fn);
      6'b000010: push(ST_JUMP, rbit(), rbit(), 0, 0, o, fn);
      6'b000011: push(ST_JAL, rbit(), rbit(), 0, 0, o, fn);
      default: for (int unsigned i = 0; i < halt_cycles; i++)
        push(ST_HALT, rbit(), rbit(), 0, 0, o, fn);
    endcase
  endtask

  // Pop up to limit entries, one per cycle: drive at negedge, compare 1 time unit later.
  task automatic drain(input int unsigned limit);
    entry_t e;
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      e = sb.pop_front();
      @(negedge clk);
      mem_ready = e.rdy; zero = e.z; op = e.op; funct = e.fn;
      #1;
      n_checks++;
      if (act !== e.vec)
        $display("FAIL trace step %0d: got %h (state %0d) expected %h", step, act, state, e.vec);
      else
        n_pass++;
      step++;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; mem_ready = 0; op = 6'($urandom); zero = rbit();
    @(negedge clk);
    reset = 0; mem_ready = 0;
    #1;
    n_checks++;
    if (act !== exp_vec(ST_FETCH, 0, 0, 0, 0))
      $display("FAIL reset_state: got %h expected %h", act, exp_vec(ST_FETCH, 0, 0, 0, 0));
    else
      n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_rtype();
    issue(6'b000000, 6'b100000, 0, 0, 0, 0);
    issue(6'b000000, 6'b100010, 0, 1, 0, 0);
    issue(6'b000000, 6'b100100, 0, 0, 0, 0);
    issue(6'b000000, 6'b100101, 0, 0, 0, 0);
    issue(6'b000000, 6'b101010, 0, 2, 0, 0);
    drain(1000);
  endtask

  task automatic test_itype();
    issue(6'b100011, 6'b000000, 0, 0, 2, 0);
    issue(6'b101011, 6'b000000, 0, 0, 1, 0);
    issue(6'b001000, 6'b000000, 0, 0, 0, 0);
    issue(6'b100011, 6'b000000, 0, 1, 0, 0);
    issue(6'b101011, 6'b000000, 0, 0, 0, 0);
    drain(1000);
  endtask

  task automatic test_branch();
    issue(6'b000100, 6'b000000, 1, 0, 0, 0);
    issue(6'b000100, 6'b000000, 0, 0, 0, 0);
    issue(6'b000101, 6'b000000, 1, 0, 0, 0);
    issue(6'b000101, 6'b000000, 0, 0, 0, 0);
    drain(1000);
  endtask

  task automatic test_jumps();
    issue(6'b000010, 6'b000000, 0, 0, 0, 0);
    issue(6'b000011, 6'b000000, 0, 0, 0, 0);
    issue(6'b000000, 6'b001000, 0, 0, 0, 0);
    drain(1000);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    ops = '{6'b100011, 6'b000000, 6'b000101, 6'b101011, 6'b000011, 6'b001000};
    for (int unsigned i = 0; i < 6; i++)
      issue(ops[i], 6'b100101, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), 0);
    drain(1000);
  endtask

  task automatic test_illegal_op();
    issue(6'b111111, 6'b100000, 0, 0, 0, 10);
    drain(1000);
    do_reset();
  endtask

  task automatic test_illegal_funct();
    issue(6'b000000, 6'b111111, 0, 0, 0, 5);
    drain(1000);
    do_reset();
  endtask

  task automatic test_reset_mid_write();
    issue(6'b101011, 6'b000000, 0, 0, 5, 0);
    drain(5);
    sb.delete();
    do_reset();
    issue(6'b000000, 6'b100000, 0, 0, 0, 0);
    drain(1000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; op = '0; funct = '0; zero = 0; mem_ready = 0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_illegal_op();
    test_illegal_funct();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
